// File: rtl/game_timer_pkg.sv
// Shared types and elaboration helpers for the game timer.
//   state_t     : controller states (CONV exists only with GAME_TIMER_BCD_EN)
//   MODE_UP/DOWN: encoding of the mode input
//   calc_div    : prescale ratio, 0 when the ratio is not an exact integer
//   calc_digits : decimal digits needed to show 0..limit
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        CONV = 2'd3
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        if (tick_hz == 0 || (clk_hz % tick_hz) != 0) return 0;
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned calc_digits(input int unsigned limit);
        int unsigned d;
        int unsigned v;
        d = 1;
        v = limit;
        while (v >= 10) begin
            v = v / 10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the game tick.
//   clk, reset : clock, asynchronous active-high reset
//   en         : advance the prescaler this cycle
//   clr        : force the prescaler back to 0 (wins over en)
//   wrap       : high in the enabled cycle where the prescaler is at DIV-1
// The value simply holds while en is low, so a pause keeps the partial tick.
module tick_prescaler #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q;

    assign wrap = en && (pre_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= wrap ? '0 : pre_q + PW'(1);
        end
    end

endmodule

// File: rtl/game_timer.sv
// Game timer: prescaled up/down counter with start, pause, preload and sticky expiry.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : pulse, begin/resume counting from IDLE
//   stop        : level, freeze the count while high (stays in RUN)
//   load        : pulse, load load_value/mode and return to IDLE
//   load_value  : preload value (saturated to LIMIT in up mode)
//   mode        : 0 up, 1 down; captured on load only
//   count       : current count
//   tick        : one-cycle pulse in the cycle after count stepped
//   running     : in RUN
//   expired     : in DONE (terminal value reached)
//   bcd         : BCD copy of count, only when GAME_TIMER_BCD_EN is defined
// Optional macro GAME_TIMER_BCD_EN adds the bcd output; after a load the binary value is
// converted by a sequential double-dabble, during which the timer reads as IDLE and start
// is ignored.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned LIMIT   = 999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             mode,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             running,
`ifdef GAME_TIMER_BCD_EN
    output logic [4*calc_digits(LIMIT)-1:0] bcd,
`endif
    output logic             expired
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    if (DIV < 2) begin : g_bad_div
        $error("game_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (64'(LIMIT) >= (64'd1 << CNT_W)) begin : g_bad_limit
        $error("game_timer: LIMIT does not fit in CNT_W bits");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             pre_en, pre_clr, wrap;
    logic [CNT_W-1:0] load_sat, step_val, term_val;
    logic             conv_done;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .wrap  (wrap)
    );

    assign load_sat = (mode == MODE_UP && load_value > LIMIT_C) ? LIMIT_C : load_value;
    assign term_val = (mode_q == MODE_UP) ? LIMIT_C : '0;
    assign step_val = (mode_q == MODE_UP) ? count_q + CNT_W'(1) : count_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        pre_en  = 1'b0;
        pre_clr = 1'b0;
        if (load) begin
            count_d = load_sat;
            mode_d  = mode;
            pre_clr = 1'b1;
`ifdef GAME_TIMER_BCD_EN
            state_d = CONV;
`else
            state_d = IDLE;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Starting at the terminal value expires at once without a step.
                    if (start) state_d = (count_q == term_val) ? DONE : RUN;
                end
                RUN: begin
                    if (!stop) begin
                        pre_en = 1'b1;
                        if (wrap) begin
                            count_d = step_val;
                            tick_d  = 1'b1;
                            if (step_val == term_val) state_d = DONE;
                        end
                    end
                end
                DONE: ;
`ifdef GAME_TIMER_BCD_EN
                CONV: begin
                    if (conv_done) state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= MODE_UP;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);

`ifdef GAME_TIMER_BCD_EN
    localparam int unsigned D  = calc_digits(LIMIT);
    localparam int unsigned CW = $clog2(CNT_W) + 1;

    logic [4*D-1:0]   bcd_q, bcd_d, bcd_step, bcd_dab;
    logic [CNT_W-1:0] bin_q, bin_d, bin_shift;
    logic [CW-1:0]    conv_q, conv_d;

    assign conv_done = (conv_q == CW'(CNT_W - 1));

    // Digit-serial +/-1: the carry/borrow ripples until a digit absorbs it.
    always_comb begin
        logic carry;
        carry    = 1'b1;
        bcd_step = bcd_q;
        for (int i = 0; i < D; i++) begin
            if (carry) begin
                if (mode_q == MODE_UP) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        bcd_step[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_step[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*i +: 4] == 4'd0) begin
                        bcd_step[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_step[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // One double-dabble iteration: add 3 to digits >= 5, then shift the binary in.
    always_comb begin
        logic [4*D-1:0] adj;
        adj = bcd_q;
        for (int i = 0; i < D; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_dab, bin_shift} = {adj, bin_q} << 1;
    end

    always_comb begin
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        conv_d = conv_q;
        if (load) begin
            bcd_d  = '0;
            bin_d  = load_sat;
            conv_d = '0;
        end else if (state_q == CONV) begin
            bcd_d  = bcd_dab;
            bin_d  = bin_shift;
            conv_d = conv_q + CW'(1);
        end else if (tick_d) begin
            bcd_d  = bcd_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            conv_q <= '0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            conv_q <= conv_d;
        end
    end

    assign bcd = bcd_q;
`else
    assign conv_done = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

    localparam int unsigned CLK_HZ  = 8;
    localparam int unsigned TICK_HZ = 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LIMIT   = 5;

    logic             clk = 1'b0;
    logic             reset, start, stop, load, mode;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] count;
    logic             tick, running, expired;
`ifdef GAME_TIMER_BCD_EN
    logic [3:0]       bcd;
`endif

    game_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W),
        .LIMIT   (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .count      (count),
        .tick       (tick),
        .running    (running),
`ifdef GAME_TIMER_BCD_EN
        .bcd        (bcd),
`endif
        .expired    (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        sbq.push_back(e);
    endtask

    // Advance to the next falling edge; any tick seen there must match the scoreboard head.
    task automatic next_cyc();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tick === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("tick_expected", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("tick_cycle", cyc, e.at);
                chk("tick_count", count, e.val);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) next_cyc();
    endtask

    task automatic do_load(input int v, input logic m);
        load_value = CNT_W'(v);
        mode       = m;
        load       = 1'b1;
        next_cyc();
        load       = 1'b0;
        repeat (CNT_W + 2) next_cyc();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; mode = 1'b0;
        load_value = '0;
        repeat (3) next_cyc();
        chk("rst_count", count, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_expired", expired, 0);
        reset = 1'b0;
        next_cyc();

        // Count up from 0 to LIMIT, then hold in DONE.
        c0 = cyc;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) push_exp(k, c0 + 1 + 8 * k);
        next_cyc();
        start = 1'b0;
        chk("up_running", running, 1);
        run_to(c0 + 41);
        chk("up_final_count", count, 5);
        chk("up_expired", expired, 1);
        chk("up_not_running", running, 0);
        run_to(c0 + 61);
        chk("up_hold_count", count, 5);
        chk("up_hold_expired", expired, 1);
        chk("up_sb_drained", sbq.size(), 0);
`ifdef GAME_TIMER_BCD_EN
        chk("up_bcd", bcd, 5);
`endif

        // Down from 3 to 0, then start in DONE is ignored.
        do_load(3, 1'b1);
        chk("ld_count", count, 3);
        chk("ld_expired", expired, 0);
        chk("ld_running", running, 0);
        c0 = cyc;
        start = 1'b1;
        push_exp(2, c0 + 9);
        push_exp(1, c0 + 17);
        push_exp(0, c0 + 25);
        next_cyc();
        start = 1'b0;
        run_to(c0 + 25);
        chk("dn_count", count, 0);
        chk("dn_expired", expired, 1);
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        run_to(cyc + 10);
        chk("dn_start_ignored_exp", expired, 1);
        chk("dn_start_ignored_run", running, 0);
        chk("dn_sb_drained", sbq.size(), 0);

        // Pause with the prescaler at 5; the partial tick survives the stop.
        do_load(0, 1'b0);
        c0 = cyc;
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        run_to(c0 + 6);
        stop = 1'b1;
        run_to(c0 + 36);
        chk("stop_running", running, 1);
        chk("stop_count", count, 0);
        stop = 1'b0;
        push_exp(1, c0 + 39);
        push_exp(2, c0 + 47);
        run_to(c0 + 50);
        chk("resume_count", count, 2);

        // load together with start while running: load wins, start dropped.
        load_value = 4'd4;
        mode = 1'b0;
        load = 1'b1;
        start = 1'b1;
        next_cyc();
        load = 1'b0;
        start = 1'b0;
        chk("ldst_count", count, 4);
        chk("ldst_expired", expired, 0);
        chk("ldst_running", running, 0);
        repeat (12) next_cyc();
        chk("ldst_idle_hold", count, 4);
        c0 = cyc;
        start = 1'b1;
        push_exp(5, c0 + 9);
        next_cyc();
        start = 1'b0;
        chk("ldst_resume_run", running, 1);
        run_to(c0 + 9);
        chk("ldst_expired_end", expired, 1);

        // Asynchronous reset between clock edges while running.
        do_load(0, 1'b0);
        c0 = cyc;
        start = 1'b1;
        push_exp(1, c0 + 9);
        next_cyc();
        start = 1'b0;
        run_to(c0 + 12);
        chk("pre_rst_count", count, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_running", running, 0);
        chk("arst_tick", tick, 0);
        chk("arst_expired", expired, 0);
        repeat (2) next_cyc();
        reset = 1'b0;
        next_cyc();

        // Up-mode load above LIMIT saturates; starting at terminal expires with no tick.
        do_load(9, 1'b0);
        chk("sat_count", count, 5);
`ifdef GAME_TIMER_BCD_EN
        chk("sat_bcd", bcd, 5);
`endif
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        chk("term_start_expired", expired, 1);
        chk("term_start_running", running, 0);
        repeat (10) next_cyc();
        chk("term_start_count", count, 5);

        // Down mode does not saturate.
        do_load(9, 1'b1);
        chk("down_nosat_count", count, 9);
        chk("final_sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
